// File: rtl/noc_port_demux.sv
// Direction demux: steers 40-bit packets into X/Y/Local show-ahead FIFOs,
// discarding and counting packets that carry the null direction code.
module noc_port_demux #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [39:0]                in_pkt,
  input  logic [1:0]                 in_dir,
  output logic                       x_valid,
  input  logic                       x_ready,
  output logic [39:0]                x_pkt,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic [39:0]                y_pkt,
  output logic                       l_valid,
  input  logic                       l_ready,
  output logic [39:0]                l_pkt,
  output logic [$clog2(DEPTH):0]     x_cnt,
  output logic [$clog2(DEPTH):0]     y_cnt,
  output logic [$clog2(DEPTH):0]     l_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned OccW     = PtrW + 1;
  localparam int unsigned NumPorts = 3;

  // Port index: 0 = X, 1 = Y, 2 = Local
  logic [39:0]      mem_q  [NumPorts][DEPTH];
  logic [39:0]      mem_d  [NumPorts][DEPTH];
  logic [PtrW-1:0]  wptr_q [NumPorts];
  logic [PtrW-1:0]  wptr_d [NumPorts];
  logic [PtrW-1:0]  rptr_q [NumPorts];
  logic [PtrW-1:0]  rptr_d [NumPorts];
  logic [OccW-1:0]  occ_q  [NumPorts];
  logic [OccW-1:0]  occ_d  [NumPorts];
  logic [39:0]      head   [NumPorts];
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [NumPorts-1:0] full;
  logic [NumPorts-1:0] nonempty;
  logic [NumPorts-1:0] port_ready;
  logic [NumPorts-1:0] push;
  logic [NumPorts-1:0] pop;
  logic                accept;

  assign port_ready = {l_ready, y_ready, x_ready};

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      full[p]     = (occ_q[p] == OccW'(DEPTH));
      nonempty[p] = (occ_q[p] != '0);
      pop[p]      = nonempty[p] & port_ready[p];
      head[p]     = nonempty[p] ? mem_q[p][rptr_q[p]] : 40'h0;
    end
  end

  // Full check ignores same-cycle pops: no pass-through when full.
  always_comb begin
    in_ready = 1'b1;
    unique case (in_dir)
      2'b01:   in_ready = ~full[0];
      2'b10:   in_ready = ~full[1];
      2'b11:   in_ready = ~full[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    push = '0;
    unique case (in_dir)
      2'b01:   push[0] = accept;
      2'b10:   push[1] = accept;
      2'b11:   push[2] = accept;
      default: push = '0;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < NumPorts; p++) begin
      wptr_d[p] = wptr_q[p];
      rptr_d[p] = rptr_q[p];
      occ_d[p]  = occ_q[p];
      if (push[p]) begin
        mem_d[p][wptr_q[p]] = in_pkt;
        wptr_d[p]           = wptr_q[p] + PtrW'(1);
      end
      if (pop[p]) begin
        rptr_d[p] = rptr_q[p] + PtrW'(1);
      end
      unique case ({push[p], pop[p]})
        2'b10:   occ_d[p] = occ_q[p] + OccW'(1);
        2'b01:   occ_d[p] = occ_q[p] - OccW'(1);
        default: occ_d[p] = occ_q[p];
      endcase
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (accept && (in_dir == 2'b00) && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NumPorts; p++) begin
        wptr_q[p] <= '0;
        rptr_q[p] <= '0;
        occ_q[p]  <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[p][e] <= 40'h0;
        end
      end
      drop_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      drop_q <= drop_d;
    end
  end

  assign x_valid  = nonempty[0];
  assign y_valid  = nonempty[1];
  assign l_valid  = nonempty[2];
  assign x_pkt    = head[0];
  assign y_pkt    = head[1];
  assign l_pkt    = head[2];
  assign x_cnt    = occ_q[0];
  assign y_cnt    = occ_q[1];
  assign l_cnt    = occ_q[2];
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_noc_port_demux.sv
// Bench for noc_port_demux: directed scenarios plus random traffic, all checked
// against a per-port queue model.
module tb_noc_port_demux;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned OccW  = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [39:0]      in_pkt;
  logic [1:0]       in_dir;
  logic             x_valid, y_valid, l_valid;
  logic             x_ready, y_ready, l_ready;
  logic [39:0]      x_pkt, y_pkt, l_pkt;
  logic [OccW-1:0]  x_cnt, y_cnt, l_cnt;
  logic [CNT_W-1:0] drop_cnt;

  noc_port_demux #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pkt   (in_pkt),
    .in_dir   (in_dir),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .x_pkt    (x_pkt),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_pkt    (y_pkt),
    .l_valid  (l_valid),
    .l_ready  (l_ready),
    .l_pkt    (l_pkt),
    .x_cnt    (x_cnt),
    .y_cnt    (y_cnt),
    .l_cnt    (l_cnt),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per port (0 = X, 1 = Y, 2 = Local) and a drop count.
  logic [39:0] mq [3][$];
  int          m_drop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [39:0] pkt, input logic [1:0] dir,
                       input logic xr, input logic yr, input logic lr);
    in_valid = v;
    in_pkt   = pkt;
    in_dir   = dir;
    x_ready  = xr;
    y_ready  = yr;
    l_ready  = lr;
  endtask

  task automatic check_outputs();
    logic             dv;
    logic [39:0]      dp;
    logic [OccW-1:0]  dc;
    int               n;
    for (int p = 0; p < 3; p++) begin
      case (p)
        0:       begin dv = x_valid; dp = x_pkt; dc = x_cnt; end
        1:       begin dv = y_valid; dp = y_pkt; dc = y_cnt; end
        default: begin dv = l_valid; dp = l_pkt; dc = l_cnt; end
      endcase
      n = mq[p].size();
      check($sformatf("valid[%0d]", p), 64'(dv), 64'(n != 0));
      check($sformatf("pkt[%0d]", p), 64'(dp), (n != 0) ? 64'(mq[p][0]) : 64'h0);
      check($sformatf("cnt[%0d]", p), 64'(dc), 64'(n));
    end
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  // One clock: check in_ready against the model, advance both, check outputs.
  task automatic cycle();
    logic       exp_ready;
    logic       acc;
    logic [2:0] pops;
    logic [2:0] rdy;
    int         port;
    port      = int'(in_dir) - 1;
    exp_ready = (in_dir == 2'b00) ? 1'b1 : (mq[port].size() != DEPTH);
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    acc = in_valid && exp_ready;
    rdy = {l_ready, y_ready, x_ready};
    for (int p = 0; p < 3; p++) pops[p] = (mq[p].size() != 0) && rdy[p];
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) if (pops[p]) void'(mq[p].pop_front());
    if (acc) begin
      if (in_dir == 2'b00) begin
        if (m_drop < 255) m_drop++;
      end else begin
        mq[port].push_back(in_pkt);
      end
    end
    check_outputs();
  endtask

  task automatic model_reset();
    for (int p = 0; p < 3; p++) mq[p].delete();
    m_drop = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 40'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single X push, all readys high
    drive(1'b1, 40'hA5_0000_0001, 2'b01, 1'b1, 1'b1, 1'b1);
    cycle();
    check("t1 x_pkt", 64'(x_pkt), 64'h00A5_0000_0001);
    check("t1 x_cnt", 64'(x_cnt), 64'd1);
    drive(1'b0, 40'h0, 2'b00, 1'b1, 1'b1, 1'b1);
    cycle();

    // 2: fill X with x_ready low, 5th refused, Y still accepts
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 40'h10_0000_0000 + 40'(i), 2'b01, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    check("t2 x_cnt full", 64'(x_cnt), 64'd4);
    drive(1'b1, 40'h10_0000_0005, 2'b01, 1'b0, 1'b0, 1'b0);
    #1;
    check("t2 in_ready x full", 64'(in_ready), 64'd0);
    drive(1'b1, 40'h20_0000_0001, 2'b10, 1'b0, 1'b0, 1'b0);
    #1;
    check("t2 in_ready y", 64'(in_ready), 64'd1);
    cycle();

    // 3: full X pops while a push is refused, then push lands next cycle
    drive(1'b1, 40'h30_0000_0009, 2'b01, 1'b1, 1'b0, 1'b0);
    cycle();
    check("t3 x_cnt after pop", 64'(x_cnt), 64'd3);
    drive(1'b1, 40'h30_0000_0009, 2'b01, 1'b0, 1'b0, 1'b0);
    cycle();
    check("t3 x_cnt refill", 64'(x_cnt), 64'd4);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 40'h0, 2'b00, 1'b1, 1'b1, 1'b1);
      cycle();
    end

    // 4: drops, then saturate the counter
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 40'h40_0000_0000 + 40'(i), 2'b00, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    check("t4 drop_cnt 3", 64'(drop_cnt), 64'd3);
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 40'h41_0000_0000 + 40'(i), 2'b00, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    check("t4 drop_cnt sat", 64'(drop_cnt), 64'd255);

    // 5: two entries per port, then asynchronous reset mid-cycle
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 40'h50_0000_0000 + 40'(i), 2'((i % 3) + 1), 1'b0, 1'b0, 1'b0);
      cycle();
    end
    check("t5 l_cnt", 64'(l_cnt), 64'd2);
    drive(1'b0, 40'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 async x_valid", 64'(x_valid), 64'd0);
    check("t5 async y_valid", 64'(y_valid), 64'd0);
    check("t5 async l_valid", 64'(l_valid), 64'd0);
    check("t5 async drop", 64'(drop_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 40'h5A_0000_00FF, 2'b11, 1'b0, 1'b0, 1'b0);
    cycle();
    check("t5 head after reset", 64'(l_pkt), 64'h005A_0000_00FF);

    // 6: random interleaved traffic
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {8'($urandom), 32'($urandom)},
            2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/noc_port_demux.md
Name: noc_port_demux

Overview:
- Sits directly downstream of the router direction-decision stage.
- Accepts a 40-bit packet together with its 2-bit direction code: 01 = X, 10 = Y, 11 = Local, 00 = none/reset.
- Steers each packet into one of three per-port FIFOs. Each FIFO drains toward the X link, the Y link or the local sink through independent valid/ready handshakes.
- Packets with direction 00 are discarded and counted.

Parameters:
- DEPTH, 4, entries per output FIFO; power of two, minimum 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream packet present.
- in_ready  output  1  demux can take the packet this cycle.
- in_pkt  input  40  packet: [39:38] source, [37:36] destination, [35:0] payload.
- in_dir  input  2  direction code from the router stage.
- x_valid  output  1  X FIFO non-empty.
- x_ready  input  1  X link accepts the head packet.
- x_pkt  output  40  X FIFO head packet.
- y_valid  output  1  Y FIFO non-empty.
- y_ready  input  1  Y link accepts the head packet.
- y_pkt  output  40  Y FIFO head packet.
- l_valid  output  1  Local FIFO non-empty.
- l_ready  input  1  local sink accepts the head packet.
- l_pkt  output  40  Local FIFO head packet.
- x_cnt, y_cnt, l_cnt  output  $clog2(DEPTH)+1 each  current occupancy of the matching FIFO.
- drop_cnt  output  CNT_W  number of packets discarded because in_dir was 00.

Behaviour:
- Reset (async assert, sync release):
  - All FIFO pointers and occupancies go to 0.
  - x_valid/y_valid/l_valid = 0.
  - drop_cnt = 0.
  - *_pkt outputs = 40'h0.
  - Reset mid-operation discards all queued packets immediately.
- in_ready is combinational from in_dir and the occupancies:
  - in_dir 01 -> !(x_cnt==DEPTH); 10 -> !(y_cnt==DEPTH); 11 -> !(l_cnt==DEPTH); 00 -> 1.
  - in_ready never depends on in_valid or on any *_ready input.
- Accept = in_valid & in_ready at the rising edge.
  - For directions 01/10/11 the packet is written at the tail of the selected FIFO; occupancy +1.
  - For direction 00 the packet is dropped; drop_cnt +1, saturating at all-ones.
- Pop = port_valid & port_ready at the rising edge; the head advances and occupancy -1.
- Output side is show-ahead:
  - port_valid = (occupancy != 0).
  - port_pkt = the head entry, driven from the storage read pointer. It is 40'h0 when the FIFO is empty.
- Latency: a packet accepted at edge N shows port_valid = 1 in the cycle after edge N, when its FIFO was empty. There is no combinational path from input to output.
- Ordering: strict FIFO order within each port. There is no ordering guarantee between different ports.
- Full FIFO: the push is refused (in_ready = 0) even if that port pops in the same cycle. There is no pass-through when full.
- Simultaneous push and pop on the same non-full, non-empty FIFO: occupancy is unchanged, and both pointers advance.
- Push into an empty FIFO in the same cycle as the (invalid) pop: the pop is ignored, because valid = 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked separately to distinguish full from empty.
- The three ports pop independently and concurrently. One port back-pressuring never stalls another, except through the in_ready gating of packets addressed to that port.
- in_pkt is stored unmodified; the demux never rewrites source or destination fields.

Test Plan:
1. Reset, then push pkt 40'hA5_0000_0001 with in_dir = 01 while all readys are 1 -> x_valid rises the next cycle with x_pkt = 40'hA5_0000_0001, x_cnt = 1. y_valid = 0 and l_valid = 0.
2. Hold x_ready = 0, push 5 packets with dir 01 (DEPTH = 4) -> the first 4 are accepted and x_cnt = 4. in_ready = 0 on the 5th. With dir = 10 in the same state, in_ready = 1 and the packet lands in the Y FIFO.
3. Full X FIFO, raise x_ready, and drive a dir-01 push in the same cycle -> the push is refused that cycle, x_cnt = 3. The push is accepted the next cycle, x_cnt back to 4. Packets drain in original order.
4. Push 3 packets with dir 00 -> in_ready = 1 each cycle, drop_cnt = 3, no FIFO changes. Preload drop_cnt to 255 with CNT_W = 8 and drop again -> drop_cnt stays 255.
5. Fill all three FIFOs to 2 entries, assert reset for 1 cycle -> all valids drop asynchronously, all counts = 0, drop_cnt = 0. The first push after reset comes out as the head.
6. Random interleaved pushes and pops over 1000 cycles with DEPTH = 4 -> the scoreboard matches per-port order. Occupancy never exceeds 4, and no packet is lost or duplicated across pointer wrap.
